pending_encoder_32x5: RTL

Sequential 32-to-5 priority encoder with per-line pending capture, the encode-side counterpart to the 5x32 line decoder. It latches single-cycle event pulses on 32 request lines and presents the index of the highest-priority enabled pending line as a 5-bit code. A valid/ack handshake lets the consumer retire one request per handshake. It sits between event sources (exception/interrupt lines, register-file write-back tags) and the control unit.

---
 rtl/pending_encoder_32x5_pkg.sv | 19 +
 rtl/line_decoder_5x32.sv | 24 ++
 rtl/prienc_32x5.sv | 31 +++
 rtl/pending_encoder_32x5.sv | 74 +++++++
 4 files changed

// File: rtl/pending_encoder_32x5_pkg.sv
// Shared definitions for the pending-request encoder and its helper blocks.
package pending_encoder_32x5_pkg;

    localparam int NUM_LINES = 32;
    localparam int CODE_W    = 5;

    localparam logic [NUM_LINES-1:0] PEND_RST  = 32'h0000_0000;
    localparam logic [CODE_W-1:0]    CODE_RST  = 5'd0;
    localparam logic                 VALID_RST = 1'b0;

    // Presented-request output register
    typedef struct packed {
        logic              valid;
        logic [CODE_W-1:0] code;
    } out_reg_t;

    localparam out_reg_t OUT_RST = '{valid: VALID_RST, code: CODE_RST};

endpackage

// File: rtl/line_decoder_5x32.sv
// 5-to-32 line decoder with enable; all outputs low when disabled.
module line_decoder_5x32
    import pending_encoder_32x5_pkg::*;
(
    input  logic                 en,
    input  logic [CODE_W-1:0]    sel,
    output logic [NUM_LINES-1:0] onehot
);

    logic [NUM_LINES-1:0] onehot_s;

    // Drive exactly one line for the selected index when enabled
    always_comb begin
        onehot_s = PEND_RST;
        if (en) begin
            onehot_s[sel] = 1'b1;
        end else begin
            onehot_s = PEND_RST;
        end
    end

    assign onehot = onehot_s;

endmodule

// File: rtl/prienc_32x5.sv
// Combinational 32-to-5 priority encoder; bit 0 has the highest priority.
module prienc_32x5
    import pending_encoder_32x5_pkg::*;
(
    input  logic [NUM_LINES-1:0] vec,
    output logic [CODE_W-1:0]    idx,
    output logic                 any
);

    logic [CODE_W-1:0] idx_s;
    logic              any_s;

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        idx_s = CODE_RST;
        any_s = 1'b0;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx_s = CODE_W'(i);
                any_s = 1'b1;
            end else begin
                idx_s = idx_s;
                any_s = any_s;
            end
        end
    end

    assign idx = idx_s;
    assign any = any_s;

endmodule

// File: rtl/pending_encoder_32x5.sv
// Captures event pulses into pending bits and presents the highest-priority
// enabled pending line with a valid/ack handshake. State updates on negedge.
module pending_encoder_32x5
    import pending_encoder_32x5_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_LINES-1:0] req,
    input  logic [NUM_LINES-1:0] mask,
    input  logic                 ack,
    output logic                 valid,
    output logic [CODE_W-1:0]    code,
    output logic [NUM_LINES-1:0] pending
);

    logic [NUM_LINES-1:0] pending_r;
    out_reg_t             out_r;

    logic                 handshake_s;
    logic                 load_s;
    logic [NUM_LINES-1:0] clr_s;
    logic [NUM_LINES-1:0] pending_next_s;
    logic [NUM_LINES-1:0] eligible_s;
    logic [CODE_W-1:0]    enc_idx_s;
    logic                 enc_any_s;

    assign handshake_s = out_r.valid & ack;
    // The output register reloads when idle or when its request retires;
    // otherwise the presented code is held even if MASK or priorities change.
    assign load_s      = ~out_r.valid | handshake_s;

    line_decoder_5x32 u_clr_dec (
        .en     (handshake_s),
        .sel    (out_r.code),
        .onehot (clr_s)
    );

    // A new request on the line being retired wins over the clear
    assign pending_next_s = (pending_r & ~clr_s) | req;
    assign eligible_s     = pending_next_s & mask;

    prienc_32x5 u_prienc (
        .vec (eligible_s),
        .idx (enc_idx_s),
        .any (enc_any_s)
    );

    // Pending capture register; masked bits stay pending
    always_ff @(negedge clk) begin
        if (reset) begin
            pending_r <= PEND_RST;
        end else begin
            pending_r <= pending_next_s;
        end
    end

    // Presented-request register, loaded from pending_next so a fresh pulse
    // is visible right after the edge that captures it
    always_ff @(negedge clk) begin
        if (reset) begin
            out_r <= OUT_RST;
        end else if (load_s) begin
            out_r.valid <= enc_any_s;
            out_r.code  <= enc_any_s ? enc_idx_s : CODE_RST;
        end else begin
            out_r <= out_r;
        end
    end

    assign valid   = out_r.valid;
    assign code    = out_r.code;
    assign pending = pending_r;

endmodule
